// File: rtl/imem_port_arbiter.sv
// Two-port front end for the asynchronous instruction ROM: fetch/debug arbitration
// with a debug anti-starvation counter, byte-to-word address decode, range checking and registered responses.
module imem_port_arbiter #(
   parameter logic [31:0] BASE_ADDR    = 32'h00400000,
   parameter int          DEPTH_LOG2   = 13,
   parameter int          STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  f_req,
   input  logic [31:0]           f_addr,
   output logic                  f_gnt,
   output logic                  f_rvalid,
   output logic [31:0]           f_rdata,
   output logic                  f_err,
   input  logic                  d_req,
   input  logic [31:0]           d_addr,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [31:0]           d_rdata,
   output logic                  d_err,
   output logic [DEPTH_LOG2-1:0] mem_a,
   input  logic [31:0]           mem_spo
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [3:0]  starve_q, starve_d;
   logic        f_gnt_s, d_gnt_s;
   logic [31:0] sel_addr_s;
   logic [29:0] word_off_s;
   logic        err_s;
   logic [31:0] rdata_s;

   logic        f_rvalid_q, f_rvalid_d;
   logic [31:0] f_rdata_q, f_rdata_d;
   logic        f_err_q, f_err_d;
   logic        d_rvalid_q, d_rvalid_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        d_err_q, d_err_d;

   // Fixed priority to fetch, except when debug has lost STARVE_LIMIT times in a row.
   always_comb begin
      f_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
      if (rst) begin
         f_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end else if (d_req && (!f_req || (starve_q == STARVE_MAX))) begin
         d_gnt_s = 1'b1;
      end else if (f_req) begin
         f_gnt_s = 1'b1;
      end else begin
         f_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end
   end

   // Word offset uses the high address bits only; misalignment is flagged separately.
   always_comb begin
      sel_addr_s = d_gnt_s ? d_addr : f_addr;
      word_off_s = sel_addr_s[31:2] - BASE_ADDR[31:2];
      err_s      = (sel_addr_s < BASE_ADDR) || (sel_addr_s[1:0] != 2'b00) ||
                   (word_off_s[29:DEPTH_LOG2] != '0);
      rdata_s    = err_s ? 32'd0 : mem_spo;
      if (f_gnt_s || d_gnt_s) begin
         mem_a = word_off_s[DEPTH_LOG2-1:0];
      end else begin
         mem_a = {DEPTH_LOG2{1'b0}};
      end
   end

   // Starvation counter and response register next-state.
   always_comb begin
      starve_d   = starve_q;
      f_rvalid_d = f_gnt_s;
      d_rvalid_d = d_gnt_s;
      f_rdata_d  = f_rdata_q;
      f_err_d    = f_err_q;
      d_rdata_d  = d_rdata_q;
      d_err_d    = d_err_q;
      if (!d_req || d_gnt_s) begin
         starve_d = 4'd0;
      end else if (starve_q < STARVE_MAX) begin
         starve_d = starve_q + 4'd1;
      end else begin
         starve_d = starve_q;
      end
      if (f_gnt_s) begin
         f_rdata_d = rdata_s;
         f_err_d   = err_s;
      end else if (d_gnt_s) begin
         d_rdata_d = rdata_s;
         d_err_d   = err_s;
      end else begin
         f_rdata_d = f_rdata_q;
         d_rdata_d = d_rdata_q;
      end
   end

   // State registers; reset also drops any response in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q   <= 4'd0;
         f_rvalid_q <= 1'b0;
         f_rdata_q  <= 32'd0;
         f_err_q    <= 1'b0;
         d_rvalid_q <= 1'b0;
         d_rdata_q  <= 32'd0;
         d_err_q    <= 1'b0;
      end else begin
         starve_q   <= starve_d;
         f_rvalid_q <= f_rvalid_d;
         f_rdata_q  <= f_rdata_d;
         f_err_q    <= f_err_d;
         d_rvalid_q <= d_rvalid_d;
         d_rdata_q  <= d_rdata_d;
         d_err_q    <= d_err_d;
      end
   end

   assign f_gnt    = f_gnt_s;
   assign d_gnt    = d_gnt_s;
   assign f_rvalid = f_rvalid_q;
   assign f_rdata  = f_rdata_q;
   assign f_err    = f_err_q;
   assign d_rvalid = d_rvalid_q;
   assign d_rdata  = d_rdata_q;
   assign d_err    = d_err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed, table-driven bench for imem_port_arbiter with a behavioural ROM model.
module tb_imem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req, d_req;
   logic [31:0] f_addr, d_addr;
   logic        f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err;
   logic [31:0] f_rdata, d_rdata, mem_spo;
   logic [12:0] mem_a;

   int n_cmp = 0;
   int n_err = 0;

   imem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_err(f_err),
      .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_err(d_err),
      .mem_a(mem_a), .mem_spo(mem_spo)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [12:0] a);
      if (a == 13'd0) return 32'h20080005;
      return {3'b101, a, 16'hC0DE};
   endfunction

   assign mem_spo = rom_word(mem_a);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        fr;
      logic [31:0] fa;
      logic        dr;
      logic [31:0] da;
      logic        fg;
      logic        dg;
      logic [12:0] ma;
      logic        ferr;
      logic        derr;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{1'b1, 32'h00400000, 1'b0, 32'h0, 1'b1, 1'b0, 13'd0,    1'b0, 1'b0};
      vecs[1]  = '{1'b1, 32'h00400004, 1'b0, 32'h0, 1'b1, 1'b0, 13'd1,    1'b0, 1'b0};
      vecs[2]  = '{1'b1, 32'h00400008, 1'b0, 32'h0, 1'b1, 1'b0, 13'd2,    1'b0, 1'b0};
      vecs[3]  = '{1'b1, 32'h00407FFC, 1'b0, 32'h0, 1'b1, 1'b0, 13'd8191, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 32'h00408000, 1'b0, 32'h0, 1'b1, 1'b0, 13'd0,    1'b1, 1'b0};
      vecs[5]  = '{1'b1, 32'h003FFFFC, 1'b0, 32'h0, 1'b1, 1'b0, 13'd8191, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 32'h00400002, 1'b0, 32'h0, 1'b1, 1'b0, 13'd0,    1'b1, 1'b0};
      vecs[7]  = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 1'b0, 13'd8191, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 32'h0, 1'b1, 32'h00400010, 1'b0, 1'b1, 13'd4,    1'b0, 1'b0};
      vecs[9]  = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 13'd0,    1'b0, 1'b0};
      vecs[10] = '{1'b0, 32'h0, 1'b1, 32'h00400001, 1'b0, 1'b1, 13'd0,    1'b0, 1'b1};
      vecs[11] = '{1'b1, 32'h0040000C, 1'b1, 32'h00400014, 1'b1, 1'b0, 13'd3, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 13'd0,    1'b0, 1'b0};

      rst = 1'b1; f_req = 1'b1; f_addr = 32'h00400000; d_req = 1'b1; d_addr = 32'h00400010;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst_mem_a", {19'd0, mem_a}, 32'd0);
      chk("rst_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
      chk("rst_err", {30'd0, f_err, d_err}, 32'd0);
      chk("rst_rdata", f_rdata | d_rdata, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 13; i++) begin
         f_req = vecs[i].fr; f_addr = vecs[i].fa; d_req = vecs[i].dr; d_addr = vecs[i].da;
         #1;
         chk($sformatf("v%0d_f_gnt", i), {31'd0, f_gnt}, {31'd0, vecs[i].fg});
         chk($sformatf("v%0d_d_gnt", i), {31'd0, d_gnt}, {31'd0, vecs[i].dg});
         chk($sformatf("v%0d_mem_a", i), {19'd0, mem_a}, {19'd0, vecs[i].ma});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_f_rvalid", i), {31'd0, f_rvalid}, {31'd0, vecs[i].fg});
         chk($sformatf("v%0d_d_rvalid", i), {31'd0, d_rvalid}, {31'd0, vecs[i].dg});
         if (vecs[i].fg) begin
            chk($sformatf("v%0d_f_err", i), {31'd0, f_err}, {31'd0, vecs[i].ferr});
            chk($sformatf("v%0d_f_rdata", i), f_rdata, vecs[i].ferr ? 32'd0 : rom_word(vecs[i].ma));
         end
         if (vecs[i].dg) begin
            chk($sformatf("v%0d_d_err", i), {31'd0, d_err}, {31'd0, vecs[i].derr});
            chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].derr ? 32'd0 : rom_word(vecs[i].ma));
         end
         @(negedge clk);
      end

      // Fetch rdata must have held across the debug-only vectors.
      chk("hold_f_rdata", f_rdata, rom_word(13'd3));

      // Starvation: both requesters held high, expect F,F,F,F,D twice.
      f_req = 1'b1; f_addr = 32'h00400000; d_req = 1'b1; d_addr = 32'h00400020;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk($sformatf("st%0d_d_gnt", c), {31'd0, d_gnt}, {31'd0, (c % 5) == 4});
         chk($sformatf("st%0d_f_gnt", c), {31'd0, f_gnt}, {31'd0, (c % 5) != 4});
         @(posedge clk);
         #1;
         chk($sformatf("st%0d_d_rvalid", c), {31'd0, d_rvalid}, {31'd0, (c % 5) == 4});
         if ((c % 5) == 4) chk($sformatf("st%0d_d_rdata", c), d_rdata, rom_word(13'd8));
         @(negedge clk);
      end

      // Reset raised during the cycle a request is accepted suppresses its response.
      d_req = 1'b0; f_req = 1'b1; f_addr = 32'h00400004;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_f_rvalid", {31'd0, f_rvalid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_f_rvalid", {31'd0, f_rvalid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
      chk("async_rst_f_rdata", f_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0; f_req = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_f_rvalid", {31'd0, f_rvalid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
